// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : State encoding for the string sequencer and baud-select
//                codes shared with uart_byte_tx.
//  Revision    : 1.0
// ============================================================================
package uart_pkg;

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_SEND = 3'd1;
    localparam logic [2:0] c_ST_WAIT = 3'd2;
    localparam logic [2:0] c_ST_GAP  = 3'd3;
    localparam logic [2:0] c_ST_DONE = 3'd4;

    localparam logic [2:0] c_BAUD_9600   = 3'd0;
    localparam logic [2:0] c_BAUD_19200  = 3'd1;
    localparam logic [2:0] c_BAUD_38400  = 3'd2;
    localparam logic [2:0] c_BAUD_57600  = 3'd3;
    localparam logic [2:0] c_BAUD_115200 = 3'd4;

endpackage
`default_nettype wire

// File: rtl/str_buf.sv
`default_nettype none
// ============================================================================
//  Module      : str_buf
//  Description : MAX_LEN x 8 register file, synchronous write, async read.
//  Revision    : 1.0
// ============================================================================
module str_buf #(
    parameter int MAX_LEN = 16,
    parameter int AW      = 4
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdata
);

    logic [7:0] r_mem [MAX_LEN];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/uart_str_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : uart_str_tx_ctrl
//  Description : Feeds a buffered byte string to uart_byte_tx one byte at a
//                time, with optional idle gap, abort and completion pulse.
//  Revision    : 1.0
// ============================================================================
module uart_str_tx_ctrl
    import uart_pkg::*;
#(
    parameter int MAX_LEN    = 16,
    parameter int AW         = 4,
    parameter int LW         = 5,
    parameter int GAP_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    input  logic [LW-1:0] str_len,
    input  logic [2:0]    baud_in,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          str_done,
    output logic          len_err,
    output logic [7:0]    data_byte,
    output logic          send_en,
    output logic [2:0]    baud_set,
    input  logic          tx_done,
    input  logic          uart_state
);

    localparam int              c_GW       = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [c_GW-1:0] c_GAP_LAST = c_GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [LW-1:0]   c_MAX_LEN  = LW'(MAX_LEN);

    logic [2:0]      r_state;
    logic [AW-1:0]   r_idx;
    logic [LW-1:0]   r_len;
    logic [c_GW-1:0] r_gap_cnt;
    logic            r_abort_pend;
    logic            r_busy;
    logic            r_str_done;
    logic            r_len_err;
    logic            r_send_en;
    logic [7:0]      r_data_byte;
    logic [2:0]      r_baud_set;

    logic [2:0]      w_state_nxt;
    logic [AW-1:0]   w_idx_nxt;
    logic [LW-1:0]   w_len_nxt;
    logic [c_GW-1:0] w_gap_nxt;
    logic            w_abort_nxt;
    logic            w_busy_nxt;
    logic            w_str_done_nxt;
    logic            w_len_err_nxt;
    logic            w_send_en_nxt;
    logic [7:0]      w_data_nxt;
    logic [2:0]      w_baud_nxt;

    logic            w_len_ok;
    logic            w_start_ok;
    logic            w_last;
    logic            w_abort_any;
    logic [7:0]      w_buf_rdata;

    str_buf #(
        .MAX_LEN (MAX_LEN),
        .AW      (AW)
    ) u_str_buf (
        .clk     (clk),
        .i_we    (wr_en && !r_busy),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (r_idx),
        .o_rdata (w_buf_rdata)
    );

    assign w_len_ok    = (str_len != '0) && (str_len <= c_MAX_LEN);
    // A start landing on the str_done cycle is dropped; the host must re-issue it.
    assign w_start_ok  = start && !r_str_done;
    assign w_last      = ({1'b0, r_idx} == (r_len - LW'(1)));
    assign w_abort_any = abort || r_abort_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= c_ST_IDLE;
            r_idx        <= '0;
            r_len        <= '0;
            r_gap_cnt    <= '0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_str_done   <= 1'b0;
            r_len_err    <= 1'b0;
            r_send_en    <= 1'b0;
            r_data_byte  <= 8'h00;
            r_baud_set   <= 3'd0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_len        <= w_len_nxt;
            r_gap_cnt    <= w_gap_nxt;
            r_abort_pend <= w_abort_nxt;
            r_busy       <= w_busy_nxt;
            r_str_done   <= w_str_done_nxt;
            r_len_err    <= w_len_err_nxt;
            r_send_en    <= w_send_en_nxt;
            r_data_byte  <= w_data_nxt;
            r_baud_set   <= w_baud_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok && w_len_ok) w_state_nxt = c_ST_SEND;
            end
            c_ST_SEND: begin
                if (w_abort_any)      w_state_nxt = c_ST_DONE;
                else if (!uart_state) w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: begin
                if (tx_done) begin
                    if (w_abort_any || w_last) w_state_nxt = c_ST_DONE;
                    else if (GAP_CYCLES == 0)  w_state_nxt = c_ST_SEND;
                    else                       w_state_nxt = c_ST_GAP;
                end
            end
            c_ST_GAP: begin
                if (w_abort_any)                  w_state_nxt = c_ST_DONE;
                else if (r_gap_cnt == c_GAP_LAST) w_state_nxt = c_ST_SEND;
            end
            c_ST_DONE: w_state_nxt = c_ST_IDLE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        w_idx_nxt      = r_idx;
        w_len_nxt      = r_len;
        w_gap_nxt      = r_gap_cnt;
        w_abort_nxt    = r_abort_pend;
        w_busy_nxt     = r_busy;
        w_str_done_nxt = 1'b0;
        w_len_err_nxt  = 1'b0;
        w_send_en_nxt  = 1'b0;
        w_data_nxt     = r_data_byte;
        w_baud_nxt     = r_baud_set;

        if (r_state != c_ST_IDLE && abort) w_abort_nxt = 1'b1;

        case (r_state)
            c_ST_IDLE: begin
                if (w_start_ok) begin
                    if (w_len_ok) begin
                        w_len_nxt  = str_len;
                        w_baud_nxt = baud_in;
                        w_idx_nxt  = '0;
                        w_gap_nxt  = '0;
                        w_busy_nxt = 1'b1;
                    end else begin
                        w_len_err_nxt = 1'b1;
                    end
                end
            end
            c_ST_SEND: begin
                if (!w_abort_any && !uart_state) begin
                    w_send_en_nxt = 1'b1;
                    w_data_nxt    = w_buf_rdata;
                end
            end
            c_ST_WAIT: begin
                if (tx_done && !w_abort_any && !w_last) begin
                    w_idx_nxt = r_idx + AW'(1);
                    w_gap_nxt = '0;
                end
            end
            c_ST_GAP: begin
                if (!w_abort_any) begin
                    w_gap_nxt = (r_gap_cnt == c_GAP_LAST) ? '0 : r_gap_cnt + c_GW'(1);
                end
            end
            c_ST_DONE: begin
                w_str_done_nxt = 1'b1;
                w_busy_nxt     = 1'b0;
                w_abort_nxt    = 1'b0;
            end
            default: ;
        endcase
    end

    assign busy      = r_busy;
    assign str_done  = r_str_done;
    assign len_err   = r_len_err;
    assign data_byte = r_data_byte;
    assign send_en   = r_send_en;
    assign baud_set  = r_baud_set;

endmodule
`default_nettype wire

// File: tb/tb_uart_str_tx_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_str_tx_ctrl
//  Description : Directed bench for uart_str_tx_ctrl with a uart_byte_tx stub.
//  Revision    : 1.0
// ============================================================================
module tb_uart_str_tx_ctrl;

    localparam int AW       = 4;
    localparam int LW       = 5;
    localparam int BYTE_CYC = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = '0;
    logic [LW-1:0] str_len = '0;
    logic [2:0]    baud_in = '0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          start_g = 1'b0;
    logic          abort_g = 1'b0;

    logic       busy, str_done, len_err, send_en, tx_done, uart_state;
    logic [7:0] data_byte;
    logic [2:0] baud_set;
    logic       busy_g, str_done_g, len_err_g, send_en_g, tx_done_g, uart_state_g;
    logic [7:0] data_byte_g;
    logic [2:0] baud_set_g;

    always #5 clk = ~clk;

    uart_str_tx_ctrl #(.MAX_LEN(16), .AW(AW), .LW(LW), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .str_len(str_len), .baud_in(baud_in), .start(start), .abort(abort),
        .busy(busy), .str_done(str_done), .len_err(len_err), .data_byte(data_byte),
        .send_en(send_en), .baud_set(baud_set), .tx_done(tx_done), .uart_state(uart_state)
    );

    uart_str_tx_ctrl #(.MAX_LEN(16), .AW(AW), .LW(LW), .GAP_CYCLES(10)) dut_gap (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .str_len(str_len), .baud_in(baud_in), .start(start_g), .abort(abort_g),
        .busy(busy_g), .str_done(str_done_g), .len_err(len_err_g), .data_byte(data_byte_g),
        .send_en(send_en_g), .baud_set(baud_set_g), .tx_done(tx_done_g), .uart_state(uart_state_g)
    );

    // Byte transmitter stubs: busy for BYTE_CYC+1 clocks, then a tx_done pulse.
    int bt_cnt, bt_cnt_g, tx_sent;
    always @(posedge clk) begin
        if (!rst_n) begin
            uart_state <= 1'b0; tx_done <= 1'b0; bt_cnt <= 0;
        end else begin
            tx_done <= 1'b0;
            if (uart_state) begin
                if (bt_cnt == 0) begin uart_state <= 1'b0; tx_done <= 1'b1; end
                else bt_cnt <= bt_cnt - 1;
            end else if (send_en) begin
                uart_state <= 1'b1; bt_cnt <= BYTE_CYC; tx_sent <= tx_sent + 1;
            end
        end
    end
    always @(posedge clk) begin
        if (!rst_n) begin
            uart_state_g <= 1'b0; tx_done_g <= 1'b0; bt_cnt_g <= 0;
        end else begin
            tx_done_g <= 1'b0;
            if (uart_state_g) begin
                if (bt_cnt_g == 0) begin uart_state_g <= 1'b0; tx_done_g <= 1'b1; end
                else bt_cnt_g <= bt_cnt_g - 1;
            end else if (send_en_g) begin
                uart_state_g <= 1'b1; bt_cnt_g <= BYTE_CYC;
            end
        end
    end

    logic [7:0] q[$];
    logic [2:0] bq[$];
    int cyc, done_cnt, err_cnt, done_cyc, last_td, sep0;
    int sends_g, done_g, last_td_g, sep_g;

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (send_en) begin q.push_back(data_byte); bq.push_back(baud_set); sep0 = cyc - last_td; end
        if (tx_done) last_td = cyc;
        if (str_done) begin done_cnt = done_cnt + 1; done_cyc = cyc; end
        if (len_err) err_cnt = err_cnt + 1;
        if (send_en_g) begin sends_g = sends_g + 1; sep_g = cyc - last_td_g; end
        if (tx_done_g) last_td_g = cyc;
        if (str_done_g) done_g = done_g + 1;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else n_pass++;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [7:0] d);
        wr_addr = a; wr_data = d; wr_en = 1'b1;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [LW-1:0] len, input logic [2:0] baud);
        str_len = len; baud_in = baud; start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic clear();
        tick(1);
        q.delete(); bq.delete();
        done_cnt = 0; err_cnt = 0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!str_done && n < 500) begin tick(1); n++; end
        chk("done_wait", 32'(n < 500), 1);
        tick(2);
    endtask

    task automatic wait_sends(input int k);
        int n = 0;
        while (q.size() < k && n < 300) begin tick(1); n++; end
        chk("sends_wait", 32'(n < 300), 1);
    endtask

    logic [7:0] hello [5] = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

    initial begin
        int bad;
        int sent0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_str_done", str_done, 0);
        chk("rst_len_err", len_err, 0);
        chk("rst_send_en", send_en, 0);
        chk("rst_data_byte", data_byte, 8'h00);
        chk("rst_baud_set", baud_set, 3'd0);
        rst_n = 1'b1;
        tick(1);

        for (int i = 0; i < 5; i++) wr(AW'(i), hello[i]);
        wr(4'd5, 8'h41); wr(4'd6, 8'h42); wr(4'd7, 8'h43);

        // HELLO at baud 4
        clear();
        go(5'd5, 3'd4);
        chk("start_busy", busy, 1);
        chk("start_no_send_yet", send_en, 0);
        tick(1);
        chk("first_send_en", send_en, 1);
        chk("first_byte", data_byte, 8'h48);
        wait_done();
        chk("hello_count", q.size(), 5);
        for (int i = 0; i < 5 && i < q.size(); i++) chk($sformatf("hello_byte%0d", i), q[i], hello[i]);
        bad = 0;
        foreach (bq[i]) if (bq[i] != 3'd4) bad++;
        chk("baud_hold", bad, 0);
        chk("hello_done_cnt", done_cnt, 1);
        chk("done_after_txdone", done_cyc - last_td, 2);
        chk("back_to_back_sep", sep0, 2);
        chk("busy_after_done", busy, 0);
        chk("done_single_cycle", str_done, 0);
        chk("data_hold", data_byte, 8'h4F);

        // invalid lengths
        clear();
        go(5'd0, 3'd1);
        tick(2);
        chk("len0_err", err_cnt, 1);
        chk("len0_busy", busy, 0);
        go(5'd17, 3'd1);
        tick(2);
        chk("len17_err", err_cnt, 2);
        chk("badlen_no_send", q.size(), 0);
        chk("badlen_no_done", done_cnt, 0);

        // 10-cycle gap instance, 2 bytes
        str_len = 5'd2; start_g = 1'b1;
        tick(1);
        start_g = 1'b0;
        begin
            int n = 0;
            while (done_g == 0 && n < 500) begin tick(1); n++; end
            chk("gap_done_wait", 32'(n < 500), 1);
        end
        tick(2);
        chk("gap_sends", sends_g, 2);
        chk("gap_sep", sep_g, 12);
        chk("gap_busy_after", busy_g, 0);

        // abort during byte 2 of 8
        clear();
        sent0 = tx_sent;
        go(5'd8, 3'd2);
        wait_sends(2);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_done();
        chk("abort_bytes", q.size(), 2);
        if (q.size() >= 2) chk("abort_byte2", q[1], 8'h45);
        chk("abort_line_bytes", tx_sent - sent0, 2);
        chk("abort_done_cnt", done_cnt, 1);
        chk("abort_busy", busy, 0);

        // full-length string accepted, then aborted before its first send
        clear();
        go(5'd16, 3'd0);
        chk("maxlen_busy", busy, 1);
        chk("maxlen_no_err", len_err, 0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        wait_done();
        chk("abort_in_send_no_byte", q.size(), 0);
        chk("abort_in_send_done", done_cnt, 1);

        // write and start while busy are ignored
        clear();
        go(5'd5, 3'd4);
        tick(3);
        wr(4'd0, 8'hFF);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        wait_done();
        tick(10);
        chk("busy_start_ignored", done_cnt, 1);
        chk("busy_run_bytes", q.size(), 5);
        clear();
        go(5'd1, 3'd4);
        wait_done();
        chk("buf_protected_len", q.size(), 1);
        if (q.size() >= 1) chk("buf_protected", q[0], 8'h48);

        // reset in the middle of byte 3
        clear();
        go(5'd5, 3'd4);
        wait_sends(3);
        tick(1);
        rst_n = 1'b0;
        tick(1);
        chk("midrst_busy", busy, 0);
        chk("midrst_send_en", send_en, 0);
        chk("midrst_data", data_byte, 8'h00);
        chk("midrst_baud", baud_set, 3'd0);
        rst_n = 1'b1;
        tick(10);
        chk("midrst_no_done", done_cnt, 0);
        clear();
        go(5'd2, 3'd4);
        wait_done();
        chk("post_rst_count", q.size(), 2);
        if (q.size() >= 2) begin
            chk("post_rst_byte0", q[0], 8'h48);
            chk("post_rst_byte1", q[1], 8'h45);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/uart_str_tx_ctrl.md
Name: uart_str_tx_ctrl

Overview:
- Sequencer that transmits a byte string through one `uart_byte_tx` instance.
- Holds a small write-loaded byte buffer. On `start` it feeds the bytes one by one to `uart_byte_tx` via `data_byte`/`send_en`, waits for each `tx_done`, and inserts an optional idle gap between bytes.
- Sits between a host/command source and `uart_byte_tx` in the uart_tx_string design. Reports `busy` and a one-cycle completion pulse.

Parameters:
- MAX_LEN, 16, buffer depth in bytes (power of two, ≥2).
- AW, 4, buffer address width, equal to log2(MAX_LEN).
- LW, 5, length width, equal to AW+1.
- GAP_CYCLES, 0, idle clocks inserted after each `tx_done` before the next `send_en` (0 = back-to-back).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, synchronous, active-low.
- wr_en  in  1  buffer write strobe.
- wr_addr  in  AW  buffer write address.
- wr_data  in  8  buffer write data.
- str_len  in  LW  number of bytes to send; sampled at start.
- baud_in  in  3  baud select; sampled at start.
- start  in  1  begin transmission (level sampled per clock).
- abort  in  1  stop after the byte currently in flight.
- busy  out  1  high from accepted start until done/abort completes.
- str_done  out  1  one-cycle pulse: string (or aborted string) finished.
- len_err  out  1  one-cycle pulse: start rejected (str_len == 0 or > MAX_LEN).
- data_byte  out  8  to `uart_byte_tx.data_byte`.
- send_en  out  1  to `uart_byte_tx.send_en`; single-cycle pulse per byte.
- baud_set  out  3  to `uart_byte_tx.baud_set`; held for the whole string.
- tx_done  in  1  from `uart_byte_tx`.
- uart_state  in  1  from `uart_byte_tx`; high while a byte is in progress.

Behaviour:
- Clock, reset, outputs
  - All state changes on `posedge clk`. The only clock is `clk`.
  - Reset is synchronous and active-low on `rst_n`.
  - Reset values: busy=0, str_done=0, len_err=0, send_en=0, data_byte=8'h00, baud_set=3'd0, state=IDLE, idx=0, gap counter=0. Buffer contents are not reset.
  - All outputs are registered.
- Buffer
  - MAX_LEN×8 register array.
  - Write when wr_en && !busy; writes while busy are ignored.
- State IDLE
  - If start && 1 ≤ str_len ≤ MAX_LEN: latch len=str_len and baud_set=baud_in, set idx=0, busy=1, go to SEND.
  - If start with an invalid length: pulse len_err for one cycle, stay in IDLE, busy stays 0.
- State SEND
  - If uart_state==0: data_byte ← buf[idx], send_en=1 for exactly this one cycle, go to WAIT.
  - Otherwise hold in SEND with send_en=0.
- State WAIT
  - send_en=0. Stay until tx_done==1.
  - On tx_done: if abort_pending or idx==len-1, go to DONE. Otherwise idx ← idx+1 and go to GAP (or straight to SEND when GAP_CYCLES==0).
- State GAP
  - Count GAP_CYCLES clocks, then go to SEND.
- State DONE
  - str_done=1 for one cycle, busy ← 0, clear abort_pending, go to IDLE.
- abort
  - Sampled in any busy state; sets sticky abort_pending. The byte in flight always completes.
  - If abort is raised in GAP or SEND before that cycle's send_en is issued, go to DONE directly.
- Latency
  - Start accepted at edge N → send_en high in cycle N+1 (uart_state idle).
  - tx_done at edge M → next send_en at cycle M+1+GAP_CYCLES+1.
- Edge cases
  - data_byte stays stable from the send_en cycle until the next SEND.
  - start while busy is ignored. A start coincident with str_done is ignored; the host must reissue it.
  - tx_done outside WAIT is ignored.
  - rst_n low mid-string returns to IDLE with reset values the next edge; no str_done is generated.
  - str_len == MAX_LEN is valid (idx wraps only at termination and is never used beyond len-1).

Decomposition:
- Shared package `uart_pkg`: state encoding (IDLE, SEND, WAIT, GAP, DONE) and BAUD_* select constants (3'd0..3'd4) shared with `uart_byte_tx`.
- One natural sub-module, `str_buf`: a MAX_LEN×8 synchronous-write / asynchronous-read register file.
- The FSM and counters stay in the top level.

Test Plan:
- Write "HELLO" (48 45 4C 4C 4F) at addresses 0–4, str_len=5, baud_in=4, pulse start → five send_en pulses carrying 48,45,4C,4C,4F in order; baud_set=4 throughout; str_done a single cycle after the 5th tx_done; busy low after it.
- str_len=0, then str_len=17, each with start → len_err pulses once per attempt; busy, send_en and str_done stay 0.
- GAP_CYCLES=10, str_len=2 → exactly 11 idle cycles between the first tx_done and the second send_en (10 gap cycles plus one SEND cycle).
- Assert abort while byte 2 of 8 is in WAIT → byte 2 completes, no further send_en, str_done pulses, 2 bytes total on rs232_tx.
- Drive wr_en to address 0 with data FF during transmission, and raise start while busy → buffer content unchanged on the next run; no second string starts.
- Drop rst_n for 1 cycle mid byte 3 → next edge busy=0, send_en=0, data_byte=00, no str_done; a new start then sends from idx 0.
